// File: rtl/line_fill_compressor.sv
// rtl/line_fill_compressor.sv - line-fill engine delivering each line compressed (dictionary keys) or plain
// Fetches NUM_BLOCKS words, collects per-word dictionary keys, then hands the line to exactly one cache.
module line_fill_compressor #(
  parameter int NUM_BLOCKS = 4,
  parameter int F1_KEY_W   = 3,
  parameter int F2_KEY_W   = 5,
  parameter int F3_KEY_W   = 8,
  parameter int STAT_W     = 32
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                fill_req_valid,
  output logic                                                fill_req_ready,
  input  logic [31:0]                                         fill_req_addr,
  input  logic                                                comp_enable,
  output logic                                                mem_req_valid,
  input  logic                                                mem_req_ready,
  output logic [31:0]                                         mem_req_addr,
  input  logic [31:0]                                         mem_req_rdata,
  output logic [31:0]                                         dict_val,
  input  logic [2:0]                                          dict_hit,
  input  logic [F1_KEY_W+F2_KEY_W+F3_KEY_W-1:0]               dict_key,
  output logic                                                plain_fill_valid,
  input  logic                                                plain_fill_ready,
  output logic [32*NUM_BLOCKS-1:0]                            plain_fill_data,
  output logic                                                comp_fill_valid,
  input  logic                                                comp_fill_ready,
  output logic [(F1_KEY_W+F2_KEY_W+F3_KEY_W)*NUM_BLOCKS-1:0]  comp_fill_data,
  output logic [31:0]                                         fill_addr,
  output logic [STAT_W-1:0]                                   stat_lines,
  output logic [STAT_W-1:0]                                   stat_comp_lines
);

  localparam int KEY_W = F1_KEY_W + F2_KEY_W + F3_KEY_W;
  localparam int CTR_W = $clog2(NUM_BLOCKS);
  localparam logic [CTR_W-1:0] LAST_WORD = CTR_W'(NUM_BLOCKS - 1);
  localparam logic [31:0] OFF_MASK = 32'(NUM_BLOCKS * 4 - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [31:0]                 base_q, base_d;
  logic [CTR_W-1:0]            ctr_q, ctr_d;
  logic                        comp_ok_q, comp_ok_d;
  logic                        comp_sel_q, comp_sel_d;
  logic [31:0]                 fill_addr_q, fill_addr_d;
  logic [32*NUM_BLOCKS-1:0]    line_q, line_d;
  logic [KEY_W*NUM_BLOCKS-1:0] keys_q, keys_d;
  logic [STAT_W-1:0]           stat_lines_q, stat_lines_d;
  logic [STAT_W-1:0]           stat_comp_q, stat_comp_d;
  logic                        deliver_ack;

  assign deliver_ack = comp_sel_q ? comp_fill_ready : plain_fill_ready;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    ctr_d        = ctr_q;
    comp_ok_d    = comp_ok_q;
    comp_sel_d   = comp_sel_q;
    fill_addr_d  = fill_addr_q;
    line_d       = line_q;
    keys_d       = keys_q;
    stat_lines_d = stat_lines_q;
    stat_comp_d  = stat_comp_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_req_valid) begin
          base_d    = fill_req_addr & ~OFF_MASK;
          ctr_d     = '0;
          comp_ok_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_req_ready) begin
          line_d[32*ctr_q +: 32]       = mem_req_rdata;
          keys_d[KEY_W*ctr_q +: KEY_W] = dict_key;
          comp_ok_d                    = comp_ok_q & (&dict_hit);
          if (ctr_q == LAST_WORD) begin
            // Path choice is frozen here so the valid and data stay stable under backpressure.
            comp_sel_d  = comp_enable & comp_ok_d;
            fill_addr_d = base_q;
            state_d     = ST_DELIVER;
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
      end
      ST_DELIVER: begin
        if (deliver_ack) begin
          stat_lines_d = stat_lines_q + STAT_W'(1);
          if (comp_sel_q) stat_comp_d = stat_comp_q + STAT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fill_addr_q  <= '0;
      stat_lines_q <= '0;
      stat_comp_q  <= '0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      stat_lines_q <= stat_lines_d;
      stat_comp_q  <= stat_comp_d;
    end
  end

  // Datapath registers are only meaningful once the FSM has written them.
  always_ff @(posedge clk) begin
    base_q     <= base_d;
    ctr_q      <= ctr_d;
    comp_ok_q  <= comp_ok_d;
    comp_sel_q <= comp_sel_d;
    line_q     <= line_d;
    keys_q     <= keys_d;
  end

  assign fill_req_ready   = (state_q == ST_IDLE);
  assign mem_req_valid    = (state_q == ST_FETCH);
  assign mem_req_addr     = base_q + 32'({ctr_q, 2'b00});
  assign dict_val         = {mem_req_rdata[24:15], mem_req_rdata[11:7],
                             mem_req_rdata[31:25], mem_req_rdata[14:12],
                             mem_req_rdata[6:0]};
  assign plain_fill_valid = (state_q == ST_DELIVER) & ~comp_sel_q;
  assign comp_fill_valid  = (state_q == ST_DELIVER) & comp_sel_q;
  assign plain_fill_data  = line_q;
  assign comp_fill_data   = keys_q;
  assign fill_addr        = fill_addr_q;
  assign stat_lines       = stat_lines_q;
  assign stat_comp_lines  = stat_comp_q;

endmodule

// File: tb/tb_line_fill_compressor.sv
// tb/tb_line_fill_compressor.sv - scoreboard bench for line_fill_compressor with a dictionary and memory model
module tb_line_fill_compressor;

  localparam int NB = 4;
  localparam int KW = 16;

  typedef struct {
    bit          comp;
    logic [127:0] plain;
    logic [63:0]  keys;
    logic [31:0]  base;
    int           lines_before;
    int           comp_before;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_req_valid, fill_req_ready;
  logic [31:0]  fill_req_addr;
  logic         comp_enable;
  logic         mem_req_valid, mem_req_ready;
  logic [31:0]  mem_req_addr, mem_req_rdata;
  logic [31:0]  dict_val;
  logic [2:0]   dict_hit;
  logic [KW-1:0] dict_key;
  logic         plain_fill_valid, plain_fill_ready;
  logic [32*NB-1:0] plain_fill_data;
  logic         comp_fill_valid, comp_fill_ready;
  logic [KW*NB-1:0] comp_fill_data;
  logic [31:0]  fill_addr, stat_lines, stat_comp_lines;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem_words [logic [31:0]];
  int errors = 0;
  int checks = 0;
  int m_lines = 0;
  int m_comp = 0;
  int mr_mode = 0;

  line_fill_compressor dut (
    .clk(clk), .reset(reset),
    .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready), .fill_req_addr(fill_req_addr),
    .comp_enable(comp_enable),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
    .dict_val(dict_val), .dict_hit(dict_hit), .dict_key(dict_key),
    .plain_fill_valid(plain_fill_valid), .plain_fill_ready(plain_fill_ready), .plain_fill_data(plain_fill_data),
    .comp_fill_valid(comp_fill_valid), .comp_fill_ready(comp_fill_ready), .comp_fill_data(comp_fill_data),
    .fill_addr(fill_addr), .stat_lines(stat_lines), .stat_comp_lines(stat_comp_lines)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Toy dictionaries: a field hits when its top bit is clear; keys are simple arithmetic hashes.
  function automatic logic [2:0] hit_f(input logic [6:0] f1, input logic [9:0] f2, input logic [14:0] f3);
    return {~f3[14], ~f2[9], ~f1[6]};
  endfunction

  function automatic logic [KW-1:0] key_f(input logic [6:0] f1, input logic [9:0] f2, input logic [14:0] f3);
    logic [2:0] k1;
    logic [4:0] k2;
    logic [7:0] k3;
    k1 = 3'((int'(f1) * 3) % 8);
    k2 = 5'((int'(f2) * 7) % 32);
    k3 = 8'((int'(f3) * 5) % 256);
    return {k3, k2, k1};
  endfunction

  always_comb begin
    dict_hit = hit_f(dict_val[6:0], dict_val[16:7], dict_val[31:17]);
    dict_key = key_f(dict_val[6:0], dict_val[16:7], dict_val[31:17]);
  end

  function automatic logic [31:0] gen_word(input logic [2:0] miss);
    logic [31:0] w;
    w = $urandom;
    w[6]  = miss[0];
    w[31] = miss[1];
    w[24] = miss[2];
    return w;
  endfunction

  initial begin : mem_driver
    forever begin
      @(negedge clk);
      case (mr_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = ~mem_req_ready;
        default: mem_req_ready = 1'($urandom_range(0, 1));
      endcase
      mem_req_rdata = mem_words.exists(mem_req_addr) ? mem_words[mem_req_addr] : 32'h0;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b0) continue;
      if (mem_req_valid && mem_req_ready) begin
        if (addr_q.size() == 0) check("mem_addr_unexpected", mem_req_addr, 32'hffff_ffff);
        else check("mem_addr", mem_req_addr, addr_q.pop_front());
      end
      if (plain_fill_valid || comp_fill_valid) begin
        check("one_valid", plain_fill_valid & comp_fill_valid, 0);
        if (exp_q.size() == 0) begin
          check("delivery_unexpected", 1, 0);
        end else begin
          e = exp_q[0];
          check("path_comp", comp_fill_valid, e.comp);
          check("fill_addr", fill_addr, e.base);
          if (e.comp) check("comp_data", comp_fill_data, e.keys);
          else check("plain_data", plain_fill_data, e.plain);
          check("stat_lines", stat_lines, e.lines_before);
          check("stat_comp_lines", stat_comp_lines, e.comp_before);
          if ((comp_fill_valid && comp_fill_ready) || (plain_fill_valid && plain_fill_ready))
            void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic load_line(input logic [31:0] base, input logic [11:0] miss, input bit ce, input bit push_exp);
    exp_t e;
    logic [31:0] w;
    logic [6:0] f1;
    logic [9:0] f2;
    logic [14:0] f3;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < NB; i++) begin
      w = gen_word(miss[3*i +: 3]);
      mem_words[base + 32'(4*i)] = w;
      f1 = w[6:0];
      f2 = {w[31:25], w[14:12]};
      f3 = {w[24:15], w[11:7]};
      ok = ok & (&hit_f(f1, f2, f3));
      e.plain[32*i +: 32] = w;
      e.keys[KW*i +: KW]  = key_f(f1, f2, f3);
      addr_q.push_back(base + 32'(4*i));
    end
    e.comp = ce && ok;
    e.base = base;
    e.lines_before = m_lines;
    e.comp_before  = m_comp;
    if (push_exp) begin
      exp_q.push_back(e);
      m_lines++;
      if (e.comp) m_comp++;
    end
  endtask

  task automatic request(input logic [31:0] addr, input bit ce, input int mode);
    mr_mode = mode;
    comp_enable = ce;
    @(negedge clk);
    check("fill_req_ready_idle", fill_req_ready, 1);
    fill_req_valid = 1'b1;
    fill_req_addr  = addr;
    @(posedge clk);
    #1;
    fill_req_valid = 1'b0;
    fill_req_addr  = $urandom;
  endtask

  task automatic run_fill(input logic [31:0] addr, input logic [11:0] miss, input bit ce,
                          input int mode, input int hold, output int lat);
    int n;
    int held;
    bit done;
    load_line(addr & ~32'(NB*4-1), miss, ce, 1'b1);
    request(addr, ce, mode);
    lat = 0; n = 0; held = 0; done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (plain_fill_valid || comp_fill_valid) begin
        if (lat == 0) lat = n;
        if (held >= hold) begin
          plain_fill_ready = plain_fill_valid;
          comp_fill_ready  = comp_fill_valid;
          done = 1'b1;
        end else begin
          // Present only the wrong-path ready while holding off.
          plain_fill_ready = comp_fill_valid;
          comp_fill_ready  = plain_fill_valid;
          held++;
        end
      end
    end
    if (!done) check("delivery_timeout", 0, 1);
    @(negedge clk);
    plain_fill_ready = 1'b0;
    comp_fill_ready  = 1'b0;
    check("valid_drop", plain_fill_valid | comp_fill_valid, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int lat;
    int n;
    reset = 1'b1;
    fill_req_valid = 1'b0;
    fill_req_addr = '0;
    comp_enable = 1'b0;
    plain_fill_ready = 1'b0;
    comp_fill_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_plain_valid", plain_fill_valid, 0);
    check("rst_comp_valid", comp_fill_valid, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_stat_lines", stat_lines, 0);
    check("rst_stat_comp", stat_comp_lines, 0);
    check("rst_fill_addr", fill_addr, 0);
    check("rst_req_ready", fill_req_ready, 1);

    run_fill(32'h0000_104C, 12'h000, 1'b1, 0, 0, lat);
    check("latency_cycles", lat, 5);
    check("stat_comp_after_first", stat_comp_lines, 1);

    run_fill(32'h0000_2008, 12'b000_100_000_000, 1'b1, 0, 1, lat);
    run_fill(32'h0000_3010, 12'h000, 1'b1, 0, 0, lat);

    run_fill(32'h0000_4004, 12'h001, 1'b1, 1, 5, lat);
    check("stat_lines_after_bp", stat_lines, 4);

    run_fill(32'h0000_5000, 12'h000, 1'b0, 0, 0, lat);
    check("stat_comp_ce0", stat_comp_lines, 2);

    // Abandon a fill with reset after three words have been accepted.
    load_line(32'h0000_6000, 12'h000, 1'b1, 1'b0);
    request(32'h0000_6000, 1'b1, 0);
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) n++;
    end
    check("abort_words_seen", n, 3);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    addr_q.delete();
    m_lines = 0;
    m_comp = 0;
    @(negedge clk);
    check("abort_mem_valid", mem_req_valid, 0);
    check("abort_no_delivery", plain_fill_valid | comp_fill_valid, 0);
    check("abort_stats", stat_lines, 0);
    check("abort_req_ready", fill_req_ready, 1);
    run_fill(32'h0000_7030, 12'h000, 1'b1, 0, 0, lat);
    check("post_abort_latency", lat, 5);

    for (int i = 0; i < 20; i++) begin
      run_fill($urandom,
               ($urandom_range(0, 1) != 0) ? 12'h000 : 12'(1 << $urandom_range(0, 11)),
               1'($urandom_range(0, 3) != 0), $urandom_range(0, 2), $urandom_range(0, 3), lat);
    end

    @(negedge clk);
    check("end_stat_lines", stat_lines, m_lines);
    check("end_stat_comp", stat_comp_lines, m_comp);
    check("end_exp_drained", exp_q.size(), 0);
    check("end_addr_drained", addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
